// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the Stage2 integer register file and its busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard_dec5to32.sv
// One-hot strobe decoder: 5-bit address to 32 strobes, LSB = address 0, all zero when disabled.
module dec5to32 (
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] onehot
);

    assign onehot = en ? (32'd1 << addr) : 32'd0;

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two bypassed combinational read ports, one write port
// and a per-register busy scoreboard set on issue and cleared on writeback.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd
);

    localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wr_dec;
    logic [NREG-1:0] iss_dec;
    logic [NREG-1:0] wr_strobe;
    logic [NREG-1:0] iss_strobe;

    dec5to32 u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_dec)
    );

    dec5to32 u_iss_dec (
        .en     (iss_en),
        .addr   (iss_rd),
        .onehot (iss_dec)
    );

    // x0 is hardwired: its write and issue strobes never fire.
    assign wr_strobe  = wr_dec  & ~X0_MASK;
    assign iss_strobe = iss_dec & ~X0_MASK;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset explicitly because reads must return 0
            // after reset; arrays without that requirement are normally left unreset.
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_strobe[i]) begin
                    regs[i] <= wr_data;
                end
            end
            // Issue is applied after the writeback clear so a same-register issue wins.
            busy <= (busy & ~wr_strobe) | iss_strobe;
        end
    end

    // NOTE: every output of a combinational process gets a default first, so no
    // path through the ifs leaves it unassigned and no latch is inferred.
    always_comb begin
        rs1_data = regs[rs1_addr];
        rs1_busy = busy[rs1_addr];
        if (rs1_addr == REG_ZERO) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end else if (wr_en && (wr_addr == rs1_addr)) begin
            rs1_data = wr_data;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        rs2_busy = busy[rs2_addr];
        if (rs2_addr == REG_ZERO) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end else if (wr_en && (wr_addr == rs2_addr)) begin
            rs2_data = wr_data;
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;

    int compared = 0;
    int failed   = 0;

    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic        model_valid = 1'b0;

    regfile_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Architectural state after each edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_busy[i] <= 1'b0;
            end
            model_valid <= 1'b1;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] <= wr_data;
                m_busy[wr_addr] <= 1'b0;
            end
            if (iss_en && iss_rd != 5'd0) begin
                m_busy[iss_rd] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_rs1_data", rs1_data, exp_data(rs1_addr));
            check("model_rs2_data", rs2_data, exp_data(rs2_addr));
            check("model_rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
            check("model_rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst    = 1'b0;
        wr_en  = 1'b0;
        iss_en = 1'b0;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
        iss_en = 1'b0; iss_rd = 5'd0; rs1_addr = 5'd3; rs2_addr = 5'd0;

        // Reset ignores the concurrent write.
        next_cycle(); idle();
        @(negedge clk);
        check("reset_x3_data", rs1_data, 32'd0);
        check("reset_x3_busy", {31'd0, rs1_busy}, 32'd0);
        check("reset_x0_data", rs2_data, 32'd0);

        // Write x5 with same-cycle bypass, then from storage.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; rs1_addr = 5'd5;
        @(negedge clk);
        check("x5_bypass", rs1_data, 32'h12345678);
        next_cycle(); idle();
        @(negedge clk);
        check("x5_stored", rs1_data, 32'h12345678);

        // Writes to x0 are dropped.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        @(negedge clk);
        check("x0_write_cycle", rs1_data, 32'd0);
        next_cycle(); idle();
        @(negedge clk);
        check("x0_after_write", rs1_data, 32'd0);

        // Issue to x7: busy only from the next cycle.
        next_cycle();
        iss_en = 1'b1; iss_rd = 5'd7; rs2_addr = 5'd7;
        @(negedge clk);
        check("x7_busy_same_cycle", {31'd0, rs2_busy}, 32'd0);
        next_cycle(); idle();
        @(negedge clk);
        check("x7_busy_next", {31'd0, rs2_busy}, 32'd1);

        // Writeback to x7 clears the hazard combinationally.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h000000A5;
        @(negedge clk);
        check("x7_wb_busy", {31'd0, rs2_busy}, 32'd0);
        check("x7_wb_data", rs2_data, 32'h000000A5);
        next_cycle(); idle();
        @(negedge clk);
        check("x7_after_busy", {31'd0, rs2_busy}, 32'd0);
        check("x7_after_data", rs2_data, 32'h000000A5);

        // Issue and write to x9 together: data lands, busy stays set.
        next_cycle();
        iss_en = 1'b1; iss_rd = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        rs1_addr = 5'd9;
        next_cycle(); idle();
        @(negedge clk);
        check("x9_data", rs1_data, 32'h55);
        check("x9_busy", {31'd0, rs1_busy}, 32'd1);

        // Issue to x0 never sets busy.
        next_cycle();
        iss_en = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
        next_cycle(); idle();
        @(negedge clk);
        check("x0_busy", {31'd0, rs1_busy}, 32'd0);

        // Both ports on x4.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h1;
        next_cycle(); idle();
        rs1_addr = 5'd4; rs2_addr = 5'd4;
        @(negedge clk);
        check("x4_port1", rs1_data, 32'h1);
        check("x4_port2", rs2_data, 32'h1);

        // Reset mid-operation drops the x10 producer and clears x4.
        next_cycle();
        iss_en = 1'b1; iss_rd = 5'd10; rs1_addr = 5'd10;
        next_cycle(); idle();
        @(negedge clk);
        check("x10_busy_before_rst", {31'd0, rs1_busy}, 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle(); idle();
        @(negedge clk);
        check("x10_busy_after_rst", {31'd0, rs1_busy}, 32'd0);
        check("x4_after_rst", rs2_data, 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst      = ($urandom_range(0, 99) == 0);
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = rand_addr();
            wr_data  = $urandom();
            iss_en   = ($urandom_range(0, 2) != 0);
            iss_rd   = rand_addr();
            rs1_addr = rand_addr();
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : rand_addr();
        end

        next_cycle(); idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
